// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush sequencing for the 5-stage MIPS datapath
module hazard_control_unit #(
  parameter int MULDIV_LATENCY = 4,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4:0]             IFID_Rs,
  input  logic [4:0]             IFID_Rt,
  input  logic                   IFID_UsesRs,
  input  logic                   IFID_UsesRt,
  input  logic                   IFID_IsMulDiv,
  input  logic                   IFID_ReadsHiLo,
  input  logic                   IDEX_MemRead,
  input  logic [4:0]             IDEX_Rt,
  input  logic                   MEM_PCSrc,
  output logic                   PCWrite,
  output logic                   IFID_Write,
  output logic                   IFID_Flush,
  output logic                   IDEX_Flush,
  output logic                   EXMEM_Flush,
  output logic                   HiLoBusy,
  output logic                   MulDivAbort,
  output logic [STALL_CNT_W-1:0] StallCycles
);

  localparam logic [3:0] MdReload = 4'(MULDIV_LATENCY - 1);
  localparam logic [STALL_CNT_W-1:0] StallMax = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] StallOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [3:0] mdCnt;
  logic       mdYoung;
  logic       loadUse;
  logic       hiLoHaz;
  logic       stall;
  logic       issue;

  assign loadUse = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IFID_UsesRs && (IFID_Rs == IDEX_Rt)) ||
                    (IFID_UsesRt && (IFID_Rt == IDEX_Rt)));
  assign hiLoHaz = (mdCnt != 4'd0) && (IFID_ReadsHiLo || IFID_IsMulDiv);
  assign stall   = loadUse || hiLoHaz;
  assign issue   = IFID_IsMulDiv && !MEM_PCSrc && !stall;

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MulDivAbort = 1'b0;
    HiLoBusy    = Reset && (mdCnt != 4'd0);
    if (!Reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (MEM_PCSrc) begin
      // Branch outranks stalls; a mul/div that entered EX last edge is on the wrong path.
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      MulDivAbort = mdYoung;
    end else if (stall) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mdCnt       <= 4'd0;
      mdYoung     <= 1'b0;
      StallCycles <= '0;
    end else begin
      if (MEM_PCSrc && mdYoung) begin
        mdCnt   <= 4'd0;
        mdYoung <= 1'b0;
      end else if (issue) begin
        mdCnt   <= MdReload;
        mdYoung <= 1'b1;
      end else begin
        mdCnt   <= (mdCnt != 4'd0) ? mdCnt - 4'd1 : 4'd0;
        mdYoung <= 1'b0;
      end
      if (!MEM_PCSrc && stall && (StallCycles != StallMax))
        StallCycles <= StallCycles + StallOne;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
  logic        IFID_UsesRs = 0, IFID_UsesRt = 0, IFID_IsMulDiv = 0, IFID_ReadsHiLo = 0;
  logic        IDEX_MemRead = 0, MEM_PCSrc = 0;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, HiLoBusy, MulDivAbort;
  logic [15:0] StallCycles;

  hazard_control_unit #(.MULDIV_LATENCY(4), .STALL_CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt),
    .IFID_IsMulDiv(IFID_IsMulDiv), .IFID_ReadsHiLo(IFID_ReadsHiLo),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .MEM_PCSrc(MEM_PCSrc),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .HiLoBusy(HiLoBusy),
    .MulDivAbort(MulDivAbort), .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  logic [22:0] expQ[$];
  int          tagQ[$];
  int          total = 0;
  int          bad = 0;
  int          vecNum = 0;
  logic        stimDone = 0;

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, HiLoBusy, MulDivAbort, StallCycles}
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      logic [22:0] e, a;
      int t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      a = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, HiLoBusy, MulDivAbort, StallCycles};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL vec%0d ctl: got ctl=%b stall=%h, want ctl=%b stall=%h",
                 t, a[22:16], a[15:0], e[22:16], e[15:0]);
      end
    end
  end

  task automatic setIn(input logic mr, input logic [4:0] xrt, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic md, input logic hl,
                       input logic br);
    IDEX_MemRead = mr; IDEX_Rt = xrt; IFID_Rs = rs; IFID_UsesRs = urs;
    IFID_Rt = rt; IFID_UsesRt = urt; IFID_IsMulDiv = md; IFID_ReadsHiLo = hl; MEM_PCSrc = br;
  endtask

  task automatic expect7(input logic [6:0] ctl, input logic [15:0] st);
    expQ.push_back({ctl, st});
    tagQ.push_back(vecNum);
    vecNum++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [6:0] RUN   = 7'b1100000;
  localparam logic [6:0] RUNB  = 7'b1100010;
  localparam logic [6:0] RST   = 7'b0011100;
  localparam logic [6:0] STL   = 7'b0001000;
  localparam logic [6:0] STLB  = 7'b0001010;
  localparam logic [6:0] BR    = 7'b1111100;
  localparam logic [6:0] BRB   = 7'b1111110;
  localparam logic [6:0] BRAB  = 7'b1111111;

  initial begin
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    repeat (3) begin expect7(RST, 16'd0); tick(); end
    Reset = 1'b1;
    expect7(RUN, 16'd0); tick();
    // load-use on rs: one stall cycle
    setIn(1, 5'd8, 5'd8, 1, 5'd3, 0, 0, 0, 0); expect7(STL, 16'd0); tick();
    setIn(0, 5'd8, 5'd8, 1, 5'd3, 0, 0, 0, 0); expect7(RUN, 16'd1); tick();
    // load to $zero never stalls
    setIn(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0); expect7(RUN, 16'd1); tick();
    setIn(1, 5'd9, 5'd2, 1, 5'd9, 1, 0, 0, 0); expect7(STL, 16'd1); tick();
    setIn(1, 5'd9, 5'd9, 0, 5'd9, 0, 0, 0, 0); expect7(RUN, 16'd2); tick();
    // mult then mflo: three stall cycles
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0); expect7(RUN, 16'd2); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0); expect7(STLB, 16'd2); tick();
    expect7(STLB, 16'd3); tick();
    expect7(STLB, 16'd4); tick();
    expect7(RUN, 16'd5); tick();
    // branch beats load-use
    setIn(1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0, 1); expect7(BR, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUN, 16'd5); tick();
    // branch one cycle after mult issue aborts it
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0); expect7(RUN, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 1); expect7(BRAB, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUN, 16'd5); tick();
    // branch two cycles after issue: older mult keeps counting
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0); expect7(RUN, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUNB, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 1); expect7(BRB, 16'd5); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUNB, 16'd5); tick();
    expect7(RUN, 16'd5); tick();
    // back-to-back mul/div waits for the first to drain
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0); expect7(RUN, 16'd5); tick();
    expect7(STLB, 16'd5); tick();
    expect7(STLB, 16'd6); tick();
    expect7(STLB, 16'd7); tick();
    expect7(RUN, 16'd8); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUNB, 16'd8); tick();
    // saturate the stall counter
    setIn(1, 5'd4, 5'd4, 1, 5'd0, 0, 0, 0, 0);
    repeat (65541) tick();
    expect7(STL, 16'hFFFF); tick();
    expect7(STL, 16'hFFFF); tick();
    // reset in the middle of a mul/div clears occupancy at once
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0); expect7(RUN, 16'hFFFF); tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0); expect7(RUNB, 16'hFFFF); tick();
    Reset = 1'b0; expect7(RST, 16'd0); tick();
    Reset = 1'b1; expect7(RUN, 16'd0); tick();
    tick();
    stimDone = 1'b1;
  end

  initial begin
    wait (stimDone == 1'b1);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath (IF, ID, EX, MEM, WB).
- Generates the PC write enable, the IF/ID write enable, and flush controls for the IF/ID, ID/EX and EX/MEM pipe registers.
- Handles three hazard classes:
  - load-use stalls;
  - structural/data stalls against a multi-cycle HI/LO multiply/divide occupancy counter;
  - taken-branch flushes resolved in MEM.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MULDIV_LATENCY, 4, EX occupancy of a mult/multu/div/divu/madd/msub in cycles; legal range 1..15.
- STALL_CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IFID_Rs  input  5  rs field of the instruction in ID.
- IFID_Rt  input  5  rt field of the instruction in ID.
- IFID_UsesRs  input  1  instruction in ID reads rs.
- IFID_UsesRt  input  1  instruction in ID reads rt.
- IFID_IsMulDiv  input  1  instruction in ID is a multi-cycle HI/LO writer.
- IFID_ReadsHiLo  input  1  instruction in ID reads HI or LO (mfhi, mflo, madd, msub).
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_Rt  input  5  destination of the load in EX.
- MEM_PCSrc  input  1  taken branch resolved in MEM this cycle.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register enable.
- IFID_Flush  output  1  zero the IF/ID register on this edge.
- IDEX_Flush  output  1  insert a bubble into ID/EX (all control bits cleared).
- EXMEM_Flush  output  1  clear EX/MEM control bits.
- HiLoBusy  output  1  multiply/divide occupancy in progress.
- MulDivAbort  output  1  pulse: the in-flight mul/div is squashed by a branch.
- StallCycles  output  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- State: 4-bit occupancy counter MdCnt, 1-bit flag MdYoung (mul/div entered EX on the previous edge), StallCycles.
- While Reset=0, asynchronously:
  - MdCnt=0, MdYoung=0, StallCycles=0.
  - PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, HiLoBusy=0, MulDivAbort=0.
- All control outputs are combinational from the current inputs and state (zero latency). State updates only on the Clk rising edge.
- LoadUse = IDEX_MemRead & (IDEX_Rt!=0) & ((IFID_UsesRs & IFID_Rs==IDEX_Rt) | (IFID_UsesRt & IFID_Rt==IDEX_Rt)).
- HiLoHaz = (MdCnt!=0) & (IFID_ReadsHiLo | IFID_IsMulDiv).
- HiLoBusy = (MdCnt!=0).
- Priority 1, MEM_PCSrc=1:
  - PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1.
  - Stalls are ignored.
  - If MdYoung=1: MulDivAbort=1 and MdCnt<=0 (the mul/div in EX is younger than the branch).
  - An older mul/div (MdYoung=0) keeps counting.
  - No new mul/div issues this cycle.
- Priority 2, Stall = LoadUse | HiLoHaz (no branch):
  - PCWrite=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0, EXMEM_Flush=0.
  - StallCycles increments, saturating at all-ones.
- Otherwise: PCWrite=1, IFID_Write=1, all flushes 0.
- Issue: a mul/div issues when IFID_IsMulDiv=1 and neither the branch nor the stall condition holds.
  - On issue: MdCnt<=MULDIV_LATENCY-1 and MdYoung<=1.
  - Otherwise MdCnt decrements toward 0 (holds at 0) and MdYoung<=0.
- MULDIV_LATENCY=1: MdCnt never leaves 0; HiLo hazards never stall.
- Back-to-back mul/div is a HiLoHaz: the second waits until MdCnt=0, then issues.
- Load-use and HiLo hazard in the same cycle: a single stall cycle is counted per cycle.
- Reset asserted mid-occupancy clears the counter immediately; no abort pulse.

Test Plan:
- Reset low for 3 cycles -> PCWrite=0, all flushes=1, StallCycles=0. Release -> PCWrite=1, IFID_Write=1, flushes=0.
- Load in EX with IDEX_Rt=8; ID reads rs=8 -> exactly 1 cycle with PCWrite=0, IFID_Write=0, IDEX_Flush=1, StallCycles=1. The same case with IDEX_Rt=0 gives no stall.
- mult issues; ID holds mflo on the next cycle, MULDIV_LATENCY=4 -> HiLoBusy=1 and a stall for 3 cycles, then mflo proceeds. StallCycles increments by 3.
- MEM_PCSrc=1 while a load-use condition is also present -> all three flushes=1, PCWrite=1, no stall, StallCycles unchanged.
- mult issues at edge t; MEM_PCSrc=1 in cycle t+1 -> MulDivAbort=1 and HiLoBusy=0 from the next cycle. The same branch in cycle t+2 gives no abort and the counter continues.
- Force 2^16+5 stall cycles -> StallCycles holds at 16'hFFFF. Reset low mid-mul/div -> HiLoBusy=0 immediately.
